// File: rtl/rca_pipe_adder.sv
// rtl/rca_pipe_adder.sv - pipelined ripple-carry add/subtract with valid/ready flow control
//
// Splits a DWIDTH-bit ripple-carry add/subtract into NSTAGES carry segments of
// SEG = DWIDTH/NSTAGES bits, one segment resolved per register stage.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      operand beat handshake
//   in_a, in_b               operands
//   in_cin                   carry-in (add) / borrow-in (subtract)
//   in_sub                   0 = add, 1 = subtract
//   out_valid / out_ready    result beat handshake
//   out_res                  result
//   out_cout                 carry-out; in subtract mode 1 = no borrow
//   out_ovf                  two's-complement signed overflow
module rca_pipe_adder #(
  parameter int DWIDTH  = 32,
  parameter int NSTAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_res,
  output logic              out_cout,
  output logic              out_ovf
);

  localparam int SEG  = DWIDTH / NSTAGES;
  localparam int LAST = NSTAGES - 1;
  localparam int MSB  = DWIDTH - 1;

  generate
    if (NSTAGES < 1 || (DWIDTH % NSTAGES) != 0) begin : g_bad_params
      $error("rca_pipe_adder: NSTAGES must be >= 1 and divide DWIDTH");
    end
  endgenerate

  // Per-stage state. a/b hold the operands (b already inverted for subtract)
  // so later stages can consume their upper segments; r holds the result
  // segments resolved so far.
  logic [NSTAGES-1:0] v_q, v_d;
  logic [NSTAGES-1:0] c_q, c_d;
  logic [DWIDTH-1:0]  a_q [NSTAGES];
  logic [DWIDTH-1:0]  a_d [NSTAGES];
  logic [DWIDTH-1:0]  b_q [NSTAGES];
  logic [DWIDTH-1:0]  b_d [NSTAGES];
  logic [DWIDTH-1:0]  r_q [NSTAGES];
  logic [DWIDTH-1:0]  r_d [NSTAGES];
  logic               ovf_q, ovf_d;

  logic [NSTAGES-1:0] adv;

  // Stage k may advance when it is empty or any later stage (or the sink)
  // can make room. Expressed as "not everything from k to the end is full,
  // or the sink is taking a beat" so no bit of adv depends on another.
  always_comb begin
    logic full;
    adv = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < NSTAGES; j++) begin
        full = full & v_q[j];
      end
      adv[k] = !full || out_ready;
    end
  end

  logic              src_v;
  logic              src_c;
  logic [DWIDTH-1:0] src_a;
  logic [DWIDTH-1:0] src_b;
  logic [DWIDTH-1:0] src_r;
  logic [SEG:0]      sum;

  always_comb begin
    v_d   = v_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    src_v = 1'b0;
    src_c = 1'b0;
    src_a = '0;
    src_b = '0;
    src_r = '0;
    sum   = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      r_d[k] = r_q[k];
    end

    for (int k = 0; k < NSTAGES; k++) begin
      if (k == 0) begin
        src_v = in_valid;
        src_a = in_a;
        src_b = in_sub ? ~in_b : in_b;
        // Subtract uses the inverted borrow as the effective carry-in.
        src_c = in_cin ^ in_sub;
        src_r = '0;
      end else begin
        src_v = v_q[(k > 0) ? k - 1 : 0];
        src_a = a_q[(k > 0) ? k - 1 : 0];
        src_b = b_q[(k > 0) ? k - 1 : 0];
        src_c = c_q[(k > 0) ? k - 1 : 0];
        src_r = r_q[(k > 0) ? k - 1 : 0];
      end

      sum = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
          + {{SEG{1'b0}}, src_c};

      if (adv[k]) begin
        v_d[k] = src_v;
        // Data only moves with a real beat so outputs hold while idle.
        if (src_v) begin
          a_d[k] = src_a;
          b_d[k] = src_b;
          r_d[k] = src_r;
          r_d[k][k*SEG +: SEG] = sum[SEG-1:0];
          c_d[k] = sum[SEG];
          if (k == LAST) begin
            ovf_d = (src_a[MSB] == src_b[MSB]) && (sum[SEG-1] != src_a[MSB]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LAST];
  assign out_res   = r_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// tb/tb_rca_pipe_adder.sv - self-checking bench for rca_pipe_adder
module tb_rca_pipe_adder;

  localparam int DW = 32;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic          out_cout;
  logic          out_ovf;

  rca_pipe_adder #(.DWIDTH(DW), .NSTAGES(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit lat_check;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [33:0] exp;
    int          acc_cyc;
  } beat_t;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, res}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint ua, ub, c, us, sa, sb, ss;
    logic signed [31:0] t;
    logic cout, ovf;
    ua = a; ub = b; c = cin;
    sa = $signed(a); sb = $signed(b);
    if (!sub) begin
      us = ua + ub + c;
      ss = sa + sb + c;
      cout = (us >= 64'sd4294967296);
    end else begin
      us = ua - ub - c;
      ss = sa - sb - c;
      cout = (us >= 0);
    end
    t = ss[31:0];
    ovf = (longint'(t) != ss);
    return {ovf, cout, us[31:0]};
  endfunction

  // Compare process: capacity rule, hold-while-stalled, in-order results.
  logic          prev_stall;
  logic [DW-1:0] prev_res;
  logic          prev_cout, prev_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_capacity", 64'(in_ready), 64'((exp_q.size() < NS) || out_ready));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", {29'd0, out_ovf, out_cout, out_res}, {29'd0, prev_ovf, prev_cout, prev_res});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{exp: model(in_a, in_b, in_cin, in_sub), acc_cyc: cyc});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {30'd0, out_ovf, out_cout, out_res}, 64'hDEAD);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("result", {30'd0, out_ovf, out_cout, out_res}, {30'd0, b.exp});
          if (lat_check) chk("latency", 64'(cyc - b.acc_cyc), 64'(NS));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      prev_cout  = out_cout;
      prev_ovf   = out_ovf;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int n = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [33:0] req, input string name);
    chk(name, {30'd0, model(a, b, cin, sub)}, {30'd0, req});
    send(a, b, cin, sub);
    repeat (NS + 2) @(posedge clk);
    #1;
  endtask

  bit rand_done;
  int t0;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1; lat_check = 1'b1;
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", {30'd0, out_ovf, out_cout, out_res}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases, each pinned against a hand-computed literal.
    directed(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, {1'b0, 1'b1, 32'h00000000}, "model_full_ripple");
    directed(32'h000000FF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000100}, "model_seg_carry8");
    directed(32'h00FFFFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h01000000}, "model_seg_carry24");
    directed(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE}, "model_sub_borrow");
    directed(32'd7, 32'd5, 1'b1, 1'b1, {1'b0, 1'b1, 32'h00000001}, "model_sub_bin");
    directed(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80000000}, "model_add_ovf");
    directed(32'h80000000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF}, "model_sub_ovf");

    // Backpressure: 10 back-to-back beats, sink stalled on cycles 3..8.
    lat_check = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (NS + 2) @(posedge clk);
    #1;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Throughput: 16 beats in 16 cycles with the sink always ready.
    lat_check = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    chk("throughput", 64'(cyc - t0), 64'd16);
    repeat (NS + 2) @(posedge clk);
    #1;

    // Random traffic with random sink stalls and idle gaps.
    lat_check = 1'b0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
          end
          send($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (NS + 4) @(posedge clk);
    #1;
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    // Reset with 3 beats in flight, first one already at the output.
    lat_check = 1'b1;
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    send(32'hCAFEF00D, 32'h00000042, 1'b1, 1'b0);
    send(32'h0BADBEEF, 32'h00000101, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_data", {30'd0, out_ovf, out_cout, out_res}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (NS + 2) @(posedge clk);
    #1;
    directed(32'd1, 32'd1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000002}, "model_post_reset");
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_pipe_adder.md
Name: rca_pipe_adder

Overview:
- Parametrised, pipelined successor to the single-cycle ripple-carry adder.
- Splits a DWIDTH-bit ripple-carry add/subtract into NSTAGES register-separated carry segments.
- Uses valid/ready handshakes on both sides, with full backpressure support.
- Sits between an operand source (testbench driver or datapath) and a result sink; sustains one operation per cycle.

Parameters:
- DWIDTH, 32, operand and result width in bits.
- NSTAGES, 4, pipeline stages; must be ≥1 and divide DWIDTH exactly (elaboration error otherwise). Segment width SEG = DWIDTH/NSTAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the operand beat this cycle.
- in_a  input  DWIDTH  operand A.
- in_b  input  DWIDTH  operand B.
- in_cin  input  1  carry-in for add; borrow-in for subtract.
- in_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts the result beat.
- out_res  output  DWIDTH  result.
- out_cout  output  1  carry-out. In subtract mode this is the inverted borrow: 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - add: {cout,res} = a + b + cin.
  - sub: {cout,res} = a + ~b + ~cin, i.e. a − b − cin.
  - ovf = (a[MSB] == b_eff[MSB]) && (res[MSB] != a[MSB]), where b_eff = b for add and ~b for sub.
  - Results are bit-exact to the unpipelined adder for every input and mode.
- Stage k (0..NSTAGES-1):
  - Adds segment k of a and b_eff plus the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Registers the partial sum, the carry and a valid bit.
  - Carries the not-yet-consumed upper operand segments forward.
  - Carries the already-computed lower result segments forward.
  - Keeps a[MSB] and b_eff[MSB] for the overflow calculation.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - in_valid and operands must stay stable while in_ready = 0.
  - out_valid, out_res, out_cout and out_ovf stay stable while out_ready = 0.
- Flow control uses per-stage advance with bubble collapsing:
  - Last stage: adv = !v[last] || out_ready.
  - Stage k < last: adv = !v[k] || adv[k+1].
  - in_ready = adv[0], a combinational chain with no combinational path from in_* to in_ready.
  - An empty stage accepts new data even while downstream is stalled.
- Latency: exactly NSTAGES cycles from input transfer to out_valid when unstalled. Throughput: 1 per cycle.
- Capacity: NSTAGES beats in flight. When all stages are valid and out_ready = 0, in_ready = 0.
- Ordering: results leave strictly in acceptance order; no drops, no duplicates.
- Simultaneous events: a full pipe with out_ready = 1 and in_valid = 1 accepts and emits in the same cycle, so in_ready = 1.
- Outputs are registered from the last stage:
  - out_res, out_cout and out_ovf hold their last value when out_valid = 0.
  - They are don't-care for checking while out_valid = 0.
- Reset (asynchronous, any time including mid-operation):
  - All stage valid bits and data registers clear to 0; in-flight beats are discarded.
  - During reset: out_valid = 0, out_res = 0, out_cout = 0, out_ovf = 0, in_ready = 1.
  - First transfer is possible on the first rising edge after rst_n deasserts.
- NSTAGES = 1 degenerates to a single registered adder with a valid/ready skid-free stage (latency 1).

Test Plan (DWIDTH=32, NSTAGES=4):
- Full carry ripple: a=0xFFFFFFFF, b=0, cin=1, add → res=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Segment-boundary carry: a=0x000000FF, b=0x00000001, cin=0 → res=0x00000100, cout=0. Also a=0x00FFFFFF, b=1 → 0x01000000.
- Subtract and borrow: a=5, b=7, cin=0, sub → res=0xFFFFFFFE, cout=0, ovf=0. a=7, b=5, cin=1, sub → res=0x00000001, cout=1.
- Signed overflow: 0x7FFFFFFF+0x00000001 → res=0x80000000, ovf=1, cout=0. Sub 0x80000000−1 → res=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: 10 back-to-back random beats with out_ready low on cycles 3–8. Required response:
  - in_ready drops once 4 beats are in flight.
  - out_* are held stable while stalled.
  - All 10 results match the reference model in order.
  - Throughput returns to 1 per cycle after the stall.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight. Required response:
  - out_valid = 0 immediately (asynchronous).
  - No stale result appears after release.
  - A new beat 1+1 yields res=2 after 4 cycles.
